// File: rtl/drrip_req_arbiter_if.sv
// Request, engine and response signal bundle for the DRRIP request arbiter.
// The master modport is the arbiter's view; slave is the requesters/engine/consumer side.
interface drrip_req_arbiter_if #(
  parameter int N_REQ           = 2,
  parameter int SET_INDEX_WIDTH = 7
) ();
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]                 req_valid;
  logic [N_REQ-1:0]                 req_ready;
  logic [N_REQ*SET_INDEX_WIDTH-1:0] req_set;
  logic [N_REQ*4-1:0]               req_way;
  logic [N_REQ-1:0]                 req_hit;

  logic                             eng_valid;
  logic                             eng_hit;
  logic                             eng_miss;
  logic [SET_INDEX_WIDTH-1:0]       eng_set_index;
  logic [3:0]                       eng_access_way;
  logic                             eng_victim_ready;
  logic [3:0]                       eng_victim_way;

  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [ID_W-1:0]                  rsp_id;
  logic [3:0]                       rsp_way;
  logic                             rsp_hit;
  logic                             rsp_err;

  modport master (
    input  req_valid, req_set, req_way, req_hit,
    input  eng_victim_ready, eng_victim_way,
    input  rsp_ready,
    output req_ready,
    output eng_valid, eng_hit, eng_miss, eng_set_index, eng_access_way,
    output rsp_valid, rsp_id, rsp_way, rsp_hit, rsp_err
  );

  modport slave (
    output req_valid, req_set, req_way, req_hit,
    output eng_victim_ready, eng_victim_way,
    output rsp_ready,
    input  req_ready,
    input  eng_valid, eng_hit, eng_miss, eng_set_index, eng_access_way,
    input  rsp_valid, rsp_id, rsp_way, rsp_hit, rsp_err
  );
endinterface

// File: rtl/drrip_req_arbiter.sv
// Round-robin front end for the DRRIP replacement engine: one lookup in flight,
// miss requests wait for a victim (with timeout), and a one-cycle idle gap follows each response.
module drrip_req_arbiter #(
  parameter int N_REQ           = 2,
  parameter int NUM_SETS        = 128,
  parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS),
  parameter int NUM_WAYS        = 16,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int CNT_BITS        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  drrip_req_arbiter_if.master bus,
  output logic                busy,
  output logic [CNT_BITS-1:0] hit_cnt,
  output logic [CNT_BITS-1:0] miss_cnt
);

  localparam int             ID_W      = $clog2(N_REQ);
  localparam int             SW        = SET_INDEX_WIDTH;
  localparam int             TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]     WAY_LIMIT = 5'(NUM_WAYS);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HIT,
    ST_MISS,
    ST_RESP,
    ST_GAP
  } state_t;

  state_t              state_reg;
  logic [ID_W-1:0]     rr_ptr_reg;
  logic [TMO_W-1:0]    tmo_reg;
  logic [CNT_BITS-1:0] hit_cnt_reg;
  logic [CNT_BITS-1:0] miss_cnt_reg;

  logic                eng_valid_reg;
  logic                eng_hit_reg;
  logic                eng_miss_reg;
  logic [SW-1:0]       eng_set_index_reg;
  logic [3:0]          eng_access_way_reg;

  logic                rsp_valid_reg;
  logic [ID_W-1:0]     rsp_id_reg;
  logic [3:0]          rsp_way_reg;
  logic                rsp_hit_reg;
  logic                rsp_err_reg;

  logic [SW-1:0]       set_arr [N_REQ];
  logic [3:0]          way_arr [N_REQ];

  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     cand_idx;
  logic [N_REQ-1:0]    grant_onehot;
  logic                grant_way_ok;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign set_arr[gi] = bus.req_set[gi*SW +: SW];
      assign way_arr[gi] = bus.req_way[gi*4 +: 4];
    end
  endgenerate

  // Search starts at rr_ptr and wraps; the first valid requester found wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_idx = ID_W'((int'(rr_ptr_reg) + k) % N_REQ);
      if (!grant_found && bus.req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Ready is gated by rst_n so every output reads zero while reset is held.
  always_comb begin
    grant_onehot = '0;
    if (state_reg == ST_IDLE && grant_found && rst_n) begin
      grant_onehot[grant_idx] = 1'b1;
    end
  end

  assign grant_way_ok = ({1'b0, way_arr[grant_idx]} < WAY_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= ST_IDLE;
      rr_ptr_reg         <= '0;
      tmo_reg            <= '0;
      hit_cnt_reg        <= '0;
      miss_cnt_reg       <= '0;
      eng_valid_reg      <= 1'b0;
      eng_hit_reg        <= 1'b0;
      eng_miss_reg       <= 1'b0;
      eng_set_index_reg  <= '0;
      eng_access_way_reg <= '0;
      rsp_valid_reg      <= 1'b0;
      rsp_id_reg         <= '0;
      rsp_way_reg        <= '0;
      rsp_hit_reg        <= 1'b0;
      rsp_err_reg        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_found) begin
            rr_ptr_reg        <= (grant_idx == LAST_ID) ? '0 : ID_W'(grant_idx + 1'b1);
            rsp_id_reg        <= grant_idx;
            rsp_hit_reg       <= bus.req_hit[grant_idx];
            eng_set_index_reg <= set_arr[grant_idx];
            if (bus.req_hit[grant_idx]) begin
              if (grant_way_ok) begin
                eng_valid_reg      <= 1'b1;
                eng_hit_reg        <= 1'b1;
                eng_access_way_reg <= way_arr[grant_idx];
                state_reg          <= ST_HIT;
              end else begin
                // Illegal way: answer with an error without touching the engine.
                eng_access_way_reg <= way_arr[grant_idx];
                rsp_valid_reg      <= 1'b1;
                rsp_way_reg        <= way_arr[grant_idx];
                rsp_err_reg        <= 1'b1;
                state_reg          <= ST_RESP;
              end
            end else begin
              eng_valid_reg      <= 1'b1;
              eng_miss_reg       <= 1'b1;
              eng_access_way_reg <= '0;
              tmo_reg            <= '0;
              if (miss_cnt_reg != {CNT_BITS{1'b1}}) begin
                miss_cnt_reg <= miss_cnt_reg + CNT_BITS'(1);
              end
              state_reg <= ST_MISS;
            end
          end
        end

        ST_HIT: begin
          eng_valid_reg <= 1'b0;
          eng_hit_reg   <= 1'b0;
          if (hit_cnt_reg != {CNT_BITS{1'b1}}) begin
            hit_cnt_reg <= hit_cnt_reg + CNT_BITS'(1);
          end
          rsp_valid_reg <= 1'b1;
          rsp_way_reg   <= eng_access_way_reg;
          rsp_err_reg   <= 1'b0;
          state_reg     <= ST_RESP;
        end

        ST_MISS: begin
          // A victim arriving on the final timeout cycle still counts as success.
          if (bus.eng_victim_ready) begin
            eng_valid_reg <= 1'b0;
            eng_miss_reg  <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_way_reg   <= bus.eng_victim_way;
            rsp_err_reg   <= 1'b0;
            state_reg     <= ST_RESP;
          end else if (tmo_reg == TMO_LAST) begin
            eng_valid_reg <= 1'b0;
            eng_miss_reg  <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_way_reg   <= '0;
            rsp_err_reg   <= 1'b1;
            state_reg     <= ST_RESP;
          end else begin
            tmo_reg <= tmo_reg + TMO_W'(1);
          end
        end

        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= ST_GAP;
          end
        end

        ST_GAP: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready      = grant_onehot;
  assign bus.eng_valid      = eng_valid_reg;
  assign bus.eng_hit        = eng_hit_reg;
  assign bus.eng_miss       = eng_miss_reg;
  assign bus.eng_set_index  = eng_set_index_reg;
  assign bus.eng_access_way = eng_access_way_reg;
  assign bus.rsp_valid      = rsp_valid_reg;
  assign bus.rsp_id         = rsp_id_reg;
  assign bus.rsp_way        = rsp_way_reg;
  assign bus.rsp_hit        = rsp_hit_reg;
  assign bus.rsp_err        = rsp_err_reg;

  assign busy     = (state_reg != ST_IDLE);
  assign hit_cnt  = hit_cnt_reg;
  assign miss_cnt = miss_cnt_reg;

endmodule
